// File: rtl/dac_pkg.sv
// dac_pkg: shared constants and FSM state type for the LTC2624 SPI driver.
//   FRAME_BITS       - bits per SPI frame
//   PAD_HI/LO_BITS   - zero padding ahead of / after command+address+data
//   CMD_*, ADDR_ALL  - LTC2624 command and address codes
//   state_t          - frame sequencer states
package dac_pkg;

  localparam int unsigned FRAME_BITS  = 32;
  localparam int unsigned PAD_HI_BITS = 8;
  localparam int unsigned PAD_LO_BITS = 4;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;
  localparam logic [3:0] ADDR_ALL         = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE,
    GAP
  } state_t;

endpackage

// File: rtl/dac_sck_gen.sv
// dac_sck_gen: SCK phase prescaler.
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   en_i       high while a frame is shifting
//   rise_en_o  strobe: SCK goes high at the coming edge
//   fall_en_o  strobe: SCK goes low at the coming edge
// Each phase lasts CLK_DIV cycles. Dropping en_i returns the prescaler to the
// start of a low phase so every frame begins with a full low phase.
module dac_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic rise_en_o,
  output logic fall_en_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          high_q, high_d;
  logic          wrap;

  always_comb begin
    wrap      = (cnt_q == LAST);
    rise_en_o = en_i && !high_q && wrap;
    fall_en_o = en_i &&  high_q && wrap;
    cnt_d     = cnt_q;
    high_d    = high_q;
    if (!en_i) begin
      cnt_d  = '0;
      high_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      high_d = ~high_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
    end
  end

endmodule

// File: rtl/dac_spi.sv
// dac_spi: serialises {8'h00, command, address, data, 4'h0} to an LTC2624.
//   CLK50MHZ, RST           clock, asynchronous active-high reset
//   data/address/command    frame contents, captured on the trigger edge
//   dactrig                 level request; held high gives back-to-back frames
//   dacdone                 one-cycle pulse at frame completion
//   busy                    frame start through end of inter-frame gap
//   SPI_SCK/SPI_MOSI/DAC_CS SPI pins (SCK idles low, MSB first, CS active-low)
//   DAC_CLR                 active-low DAC clear, released after reset
module dac_spi
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  input  logic [11:0] data,
  input  logic [3:0]  address,
  input  logic [3:0]  command,
  input  logic        dactrig,
  output logic        dacdone,
  output logic        busy,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  output logic        DAC_CS,
  output logic        DAC_CLR
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] WAIT_LAST = CW'(CLK_DIV - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sreg_q, sreg_d;
  logic [19:0]             word_q, word_d;
  logic                    pend_q, pend_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [CW-1:0]           wait_q, wait_d;
  logic                    cs_q, cs_d;
  logic                    sck_q, sck_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    clr_q;
  logic                    rise_en, fall_en;

  dac_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk_i     (CLK50MHZ),
    .rst_i     (RST),
    .en_i      (state_q == SHIFT),
    .rise_en_o (rise_en),
    .fall_en_o (fall_en)
  );

  // Inputs are captured into word_q on the trigger edge; the shift register
  // loads one edge later. GAP's last edge doubles as a trigger edge so a held
  // dactrig gives a 66*CLK_DIV+2 cycle frame period.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    word_d  = word_q;
    pend_d  = pend_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sck_d  = 1'b0;
        busy_d = 1'b0;
        if (pend_q) begin
          sreg_d  = {{PAD_HI_BITS{1'b0}}, word_q, {PAD_LO_BITS{1'b0}}};
          pend_d  = 1'b0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = BW'(FRAME_BITS - 1);
          state_d = SHIFT;
        end else if (dactrig) begin
          word_d = {command, address, data};
          pend_d = 1'b1;
        end
      end
      SHIFT: begin
        if (rise_en) begin
          sck_d = 1'b1;
        end else if (fall_en) begin
          sck_d  = 1'b0;
          sreg_d = {sreg_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == '0) begin
            wait_d  = '0;
            state_d = HOLD;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end
      end
      HOLD: begin
        if (wait_q == WAIT_LAST) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      DONE: begin
        wait_d  = '0;
        state_d = GAP;
      end
      GAP: begin
        if (wait_q == WAIT_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (dactrig) begin
            word_d = {command, address, data};
            pend_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      word_q  <= '0;
      pend_q  <= 1'b0;
      bit_q   <= '0;
      wait_q  <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
      bit_q   <= bit_d;
      wait_q  <= wait_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= 1'b1;
    end
  end

  assign dacdone  = done_q;
  assign busy     = busy_q;
  assign SPI_SCK  = sck_q;
  assign SPI_MOSI = sreg_q[FRAME_BITS-1];
  assign DAC_CS   = cs_q;
  assign DAC_CLR  = clr_q;

endmodule
